// File: rtl/pipeline_stall_unit.sv
// rtl/pipeline_stall_unit.sv - hazard/stall controller for an in-order pipeline
module pipeline_stall_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  IF_ID_RsAddr_i,
    input  logic [4:0]  IF_ID_RtAddr_i,
    input  logic        ID_EX_MemRead_i,
    input  logic [4:0]  ID_EX_RtAddr_i,
    input  logic        Branch_Taken_i,
    input  logic        DMem_Req_i,
    input  logic        DMem_Ready_i,
    output logic        PC_Write_o,
    output logic        IF_ID_Write_o,
    output logic        IF_ID_Flush_o,
    output logic        ID_EX_Bubble_o,
    output logic        Pipe_Hold_o,
    output logic [15:0] Stall_Count_o,
    output logic        Mem_Timeout_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        timeout_q, timeout_d;

    logic load_use;
    logic mem_busy;

    // Hazard detection; an access with no request is not a memory event
    always_comb begin
        load_use = ID_EX_MemRead_i && (ID_EX_RtAddr_i != 5'd0) &&
                   ((ID_EX_RtAddr_i == IF_ID_RsAddr_i) || (ID_EX_RtAddr_i == IF_ID_RtAddr_i));
        mem_busy = DMem_Req_i && !DMem_Ready_i;
    end

    // Next state and pipeline controls: memory wait beats load-use beats branch flush
    always_comb begin
        state_d        = RUN;
        PC_Write_o     = 1'b1;
        IF_ID_Write_o  = 1'b1;
        IF_ID_Flush_o  = 1'b0;
        ID_EX_Bubble_o = 1'b0;
        Pipe_Hold_o    = 1'b0;
        if (mem_busy) begin
            PC_Write_o    = 1'b0;
            IF_ID_Write_o = 1'b0;
            Pipe_Hold_o   = 1'b1;
            state_d       = MEM_WAIT;
        end else if (load_use) begin
            // The branch, if any, is dropped here and seen again next cycle
            PC_Write_o     = 1'b0;
            IF_ID_Write_o  = 1'b0;
            ID_EX_Bubble_o = 1'b1;
            state_d        = LU_STALL;
        end else if (Branch_Taken_i) begin
            IF_ID_Flush_o = 1'b1;
        end
        if (!rst_i) begin
            PC_Write_o     = 1'b0;
            IF_ID_Write_o  = 1'b0;
            IF_ID_Flush_o  = 1'b0;
            ID_EX_Bubble_o = 1'b0;
            Pipe_Hold_o    = 1'b0;
            state_d        = RUN;
        end
    end

    // Wait counter restarts on entry to MEM_WAIT, saturates, and arms the sticky timeout
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (mem_busy) begin
            if (state_q != MEM_WAIT) begin
                wait_cnt_d = 8'd0;
            end else if (wait_cnt_q != 8'hFF) begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end
        timeout_d = timeout_q || (wait_cnt_d == 8'hFF);
    end

    // Saturating count of cycles in which the PC did not advance
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!PC_Write_o && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= RUN;
            wait_cnt_q  <= 8'd0;
            stall_cnt_q <= 16'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign Stall_Count_o = stall_cnt_q;
    assign Mem_Timeout_o = timeout_q;

endmodule
